// File: rtl/pipe_controller.sv
// ID/EX pipeline controller: decode, load-use stall, multi-cycle M-extension hold
// and branch-redirect flushing for a 5-stage RV32 pipeline.
module pipe_controller #(
  parameter int MD_LAT  = 4,
  parameter int EN_MEXT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_redirect,
  output logic        id_stall,
  output logic        flush_ifid,
  output logic        ex_valid,
  output logic [12:0] ex_ctrl,
  output logic [4:0]  ex_rd,
  output logic        md_busy
);

  typedef enum logic {RUN, MD} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        ex_valid_next;
  logic [12:0] ex_ctrl_next;
  logic [4:0]  ex_rd_next;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic [12:0] dec_ctrl;
  logic        use_rs1, use_rs2;
  logic        load_use, md_hold;
  logic        unused_funct3;

  assign opcode        = id_instr[6:0];
  assign rs1           = id_instr[19:15];
  assign rs2           = id_instr[24:20];
  assign unused_funct3 = ^id_instr[14:12];

  always_comb begin
    dec_ctrl = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec_ctrl[2]   = 1'b1;
        dec_ctrl[7:6] = 2'b10;
        dec_ctrl[12]  = (EN_MEXT == 1) && (id_instr[31:25] == 7'b0000001);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec_ctrl[0] = 1'b1;
        dec_ctrl[2] = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LW: begin
        dec_ctrl[3:0] = 4'b1111;
        use_rs1 = 1'b1;
      end
      OP_SW: begin
        dec_ctrl[0] = 1'b1;
        dec_ctrl[4] = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BR: begin
        dec_ctrl[5]   = 1'b1;
        dec_ctrl[7:6] = 2'b01;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl[8] = 1'b1;
        dec_ctrl[2] = 1'b1;
      end
      OP_JALR: begin
        dec_ctrl[9] = 1'b1;
        dec_ctrl[2] = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_AUIPC: begin
        dec_ctrl[10] = 1'b1;
        dec_ctrl[2]  = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl[11] = 1'b1;
        dec_ctrl[2]  = 1'b1;
      end
      default: dec_ctrl = '0;
    endcase
  end

  // The final MD cycle (count==0) behaves like RUN so the waiting ID instruction is consumed.
  assign md_hold  = (state == MD) && (count != 4'd0);
  assign load_use = ex_valid && ex_ctrl[3] && (ex_rd != 5'd0) && id_valid &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

  assign flush_ifid = ex_redirect;
  assign id_stall   = !ex_redirect && (md_hold || load_use);
  assign md_busy    = (state == MD);

  always_comb begin
    state_next    = RUN;
    count_next    = 4'd0;
    ex_valid_next = 1'b0;
    ex_ctrl_next  = '0;
    ex_rd_next    = '0;
    if (ex_redirect) begin
      state_next = RUN;
    end else if (md_hold) begin
      state_next    = MD;
      count_next    = count - 4'd1;
      ex_valid_next = ex_valid;
      ex_ctrl_next  = ex_ctrl;
      ex_rd_next    = ex_rd;
    end else if (load_use) begin
      state_next = RUN;
    end else begin
      ex_valid_next = id_valid;
      ex_ctrl_next  = id_valid ? dec_ctrl : 13'd0;
      ex_rd_next    = id_instr[11:7];
      if (id_valid && dec_ctrl[12]) begin
        state_next = MD;
        count_next = MD_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      count    <= 4'd0;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      ex_valid <= ex_valid_next;
      ex_ctrl  <= ex_ctrl_next;
      ex_rd    <= ex_rd_next;
    end
  end

endmodule

// File: tb/tb_pipe_controller.sv
// Directed self-checking bench for pipe_controller; a second instance with
// EN_MEXT=0 shares the stimulus to check MUL decoding as a plain R instruction.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_redirect;
  logic        id_stall, flush_ifid, ex_valid, md_busy;
  logic [12:0] ex_ctrl;
  logic [4:0]  ex_rd;
  logic        id_stall_nm, flush_ifid_nm, ex_valid_nm, md_busy_nm;
  logic [12:0] ex_ctrl_nm;
  logic [4:0]  ex_rd_nm;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h00012283;
  localparam logic [31:0] ADD  = 32'h00328333;
  localparam logic [31:0] JALR = 32'h000100E7;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] MUL  = 32'h02208033;

  pipe_controller #(.MD_LAT(4), .EN_MEXT(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .ex_redirect(ex_redirect), .id_stall(id_stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .md_busy(md_busy)
  );

  pipe_controller #(.MD_LAT(4), .EN_MEXT(0)) dut_nm (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .ex_redirect(ex_redirect), .id_stall(id_stall_nm), .flush_ifid(flush_ifid_nm),
    .ex_valid(ex_valid_nm), .ex_ctrl(ex_ctrl_nm), .ex_rd(ex_rd_nm), .md_busy(md_busy_nm)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic redir, input logic rst);
    reset       = rst;
    id_valid    = v;
    id_instr    = instr;
    ex_redirect = redir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rst_ex_rd", 32'(ex_rd), 32'd0);
    checkOutput("rst_md_busy", 32'(md_busy), 32'd0);
    checkOutput("rst_id_stall", 32'(id_stall), 32'd0);
    checkOutput("rst_flush", 32'(flush_ifid), 32'd0);

    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    checkOutput("addi_stall", 32'(id_stall), 32'd0);
    tick();
    checkOutput("addi_valid", 32'(ex_valid), 32'd1);
    checkOutput("addi_ctrl", 32'(ex_ctrl), 32'h005);
    checkOutput("addi_rd", 32'(ex_rd), 32'd1);

    applyStimulus(1'b1, LW, 1'b0, 1'b0);
    tick();
    checkOutput("lw_ctrl", 32'(ex_ctrl), 32'h00F);
    checkOutput("lw_rd", 32'(ex_rd), 32'd5);
    applyStimulus(1'b1, ADD, 1'b0, 1'b0);
    checkOutput("lu_stall", 32'(id_stall), 32'd1);
    tick();
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("lu_stall_released", 32'(id_stall), 32'd0);
    tick();
    checkOutput("add_valid", 32'(ex_valid), 32'd1);
    checkOutput("add_ctrl", 32'(ex_ctrl), 32'h084);
    checkOutput("add_rd", 32'(ex_rd), 32'd6);

    // A load whose rd is not read by the next instruction must not stall.
    applyStimulus(1'b1, LW, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    checkOutput("lw_indep_stall", 32'(id_stall), 32'd0);
    tick();

    applyStimulus(1'b1, JALR, 1'b0, 1'b0);
    tick();
    checkOutput("jalr_ctrl", 32'(ex_ctrl), 32'h204);
    checkOutput("jalr_memwrite", 32'(ex_ctrl[4]), 32'd0);
    applyStimulus(1'b1, BEQ, 1'b0, 1'b0);
    tick();
    checkOutput("beq_ctrl", 32'(ex_ctrl), 32'h060);
    applyStimulus(1'b0, ADDI, 1'b0, 1'b0);
    tick();
    checkOutput("novalid_valid", 32'(ex_valid), 32'd0);
    checkOutput("novalid_ctrl", 32'(ex_ctrl), 32'd0);

    applyStimulus(1'b1, MUL, 1'b0, 1'b0);
    checkOutput("mul_pre_stall", 32'(id_stall), 32'd0);
    tick();
    checkOutput("nm_mul_ctrl", 32'(ex_ctrl_nm), 32'h084);
    checkOutput("nm_mul_busy", 32'(md_busy_nm), 32'd0);
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    checkOutput("nm_mul_stall", 32'(id_stall_nm), 32'd0);
    checkOutput("md1_busy", 32'(md_busy), 32'd1);
    checkOutput("md1_stall", 32'(id_stall), 32'd1);
    checkOutput("md1_ctrl", 32'(ex_ctrl), 32'h1084);
    tick();
    checkOutput("md2_busy", 32'(md_busy), 32'd1);
    checkOutput("md2_stall", 32'(id_stall), 32'd1);
    checkOutput("md2_ctrl", 32'(ex_ctrl), 32'h1084);
    tick();
    checkOutput("md3_busy", 32'(md_busy), 32'd1);
    checkOutput("md3_stall", 32'(id_stall), 32'd1);
    checkOutput("md3_ctrl", 32'(ex_ctrl), 32'h1084);
    tick();
    checkOutput("md4_busy", 32'(md_busy), 32'd1);
    checkOutput("md4_stall", 32'(id_stall), 32'd0);
    checkOutput("md4_ctrl", 32'(ex_ctrl), 32'h1084);
    tick();
    checkOutput("md_done_busy", 32'(md_busy), 32'd0);
    checkOutput("md_done_ctrl", 32'(ex_ctrl), 32'h005);

    applyStimulus(1'b1, MUL, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, ADDI, 1'b1, 1'b0);
    checkOutput("redir_flush", 32'(flush_ifid), 32'd1);
    checkOutput("redir_stall", 32'(id_stall), 32'd0);
    tick();
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    checkOutput("redir_valid", 32'(ex_valid), 32'd0);
    checkOutput("redir_busy", 32'(md_busy), 32'd0);
    checkOutput("redir_flush_off", 32'(flush_ifid), 32'd0);

    applyStimulus(1'b1, MUL, 1'b0, 1'b0);
    tick();
    checkOutput("rstmd_busy_pre", 32'(md_busy), 32'd1);
    applyStimulus(1'b1, ADDI, 1'b0, 1'b1);
    tick();
    checkOutput("rstmd_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rstmd_busy", 32'(md_busy), 32'd0);
    checkOutput("rstmd_valid", 32'(ex_valid), 32'd0);
    checkOutput("rstmd_stall", 32'(id_stall), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, meaning the number of EX-hold cycles for an M-extension instruction (legal range 1..15).
REQ-002 SHALL have parameter EN_MEXT, default 1, meaning M-extension decode is enabled when 1.
REQ-003 SHALL have input clk (1 bit), the single rising-edge clock.
REQ-004 SHALL have input reset (1 bit), synchronous, active-high.
REQ-005 SHALL have input id_valid (1 bit): the ID stage holds a valid instruction.
REQ-006 SHALL have input id_instr (32 bits): the ID-stage instruction word.
REQ-007 SHALL have input ex_redirect (1 bit): a taken branch, JAL or JALR resolved in EX this cycle.
REQ-008 SHALL have output id_stall (1 bit): hold the PC and the IF/ID register this cycle.
REQ-009 SHALL have output flush_ifid (1 bit): invalidate the IF/ID register at the next edge.
REQ-010 SHALL have output ex_valid (1 bit): the ID/EX register holds a real instruction.
REQ-011 SHALL have output ex_ctrl (13 bits): the registered control bundle. Bit map [0] ALUSrc, [1] MemtoReg, [2] RegWrite, [3] MemRead, [4] MemWrite, [5] Branch, [7:6] ALUOp, [8] Jal, [9] Jalr, [10] AUIPC, [11] LUI, [12] MD.
REQ-012 SHALL have output ex_rd (5 bits): the registered destination register.
REQ-013 SHALL have output md_busy (1 bit): the FSM is in state MD.

Function
REQ-014 Decode from opcode = id_instr[6:0]. Bit settings per opcode:
- R 0110011: RegWrite, ALUOp=10.
- I-ALU 0010011: ALUSrc, RegWrite.
- LW 0000011: ALUSrc, MemtoReg, MemRead, RegWrite.
- SW 0100011: ALUSrc, MemWrite.
- BR 1100011: Branch, ALUOp=01.
- JAL 1101111: Jal, RegWrite.
- JALR 1100111: Jalr, RegWrite. MemWrite stays 0.
- AUIPC 0010111: AUIPC, RegWrite.
- LUI 0110111: LUI, RegWrite.
- Any other opcode: all zero.
REQ-015 MD=1 only when EN_MEXT=1, the opcode is R, and id_instr[31:25]=0000001.
REQ-016 The ID stage uses rs1 (id_instr[19:15]) for R, I-ALU, LW, SW, BR and JALR, and uses rs2 (id_instr[24:20]) for R, SW and BR.
REQ-017 Load-use hazard:
- Condition: ex_valid=1, ex_ctrl[3]=1, ex_rd!=0, id_valid=1, and ex_rd equals a used rs1 or rs2.
- Response: id_stall=1; at the next edge the block loads a bubble (ex_valid=0, ex_ctrl=0, ex_rd=0).
REQ-018 The FSM has two states, RUN and MD.
REQ-019 In RUN, an accepted ID instruction with MD=1 loads ID/EX, moves the FSM to MD, and loads the counter with MD_LAT-1.
REQ-020 In MD, id_stall=1 and ex_valid, ex_ctrl and ex_rd hold their values. The counter decrements each cycle. At counter=0 the FSM returns to RUN, and id_stall deasserts in that same cycle.
REQ-021 ex_redirect=1 causes:
- flush_ifid=1 in the same cycle, combinationally;
- a bubble loaded into ID/EX at the next edge;
- FSM forced to RUN and counter cleared;
- id_stall=0 in that cycle.
REQ-022 Priority is reset > ex_redirect > MD hold > load-use > normal load.
REQ-023 Normal load: ID/EX takes the decoded bundle, rd=id_instr[11:7] and ex_valid=id_valid. When id_valid=0 the block loads ex_ctrl=0.
REQ-024 id_stall and flush_ifid are combinational. All other outputs are registered with a latency of 1 cycle.

Reset
REQ-025 At reset=1 at a clock edge:
- ex_valid=0, ex_ctrl=0, ex_rd=0;
- FSM=RUN, counter=0;
- md_busy=0, id_stall=0, flush_ifid=0 from that edge onward.
REQ-026 Reset asserted while in MD aborts the hold with no further ex_ctrl change.

Verification
REQ-027 ADDI x1,x0,5 (0x00500093), id_valid=1 -> next cycle: ex_valid=1, ex_ctrl=0x005, ex_rd=1, id_stall=0.
REQ-028 LW x5,0(x2), then ADD x6,x5,x3 in ID -> id_stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADD loads with ex_ctrl=0x084.
REQ-029 JALR x1,0(x2) (0x000100E7) -> ex_ctrl=0x204; ex_ctrl[4]=0.
REQ-030 MUL (0x02208033) with MD_LAT=4 -> md_busy=1 for 4 cycles, id_stall=1 for 3 cycles, and ex_ctrl=0x1084 held throughout.
REQ-031 ex_redirect=1 during MD, with the count at 2 -> flush_ifid=1 that cycle, next cycle ex_valid=0 and md_busy=0.
REQ-032 Reset asserted mid-MD -> next edge: ex_ctrl=0, md_busy=0; EN_MEXT=0 decodes MUL as plain R (0x084, no hold).
